// File: rtl/hack_memory_map.sv
// Hack CPU data-memory responder: 16K data RAM, screen-write FIFO, keyboard register.
// Optional screen shadow RAM enabled by defining HACK_SCREEN_SHADOW_EN.
module hack_memory_map #(
   parameter int unsigned SCR_FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [14:0] addressM,
   input  logic [15:0] outM,
   input  logic        writeM,
   output logic [15:0] inM,
   input  logic        kbd_valid,
   input  logic [15:0] kbd_code,
   output logic        kbd_ready,
   output logic        scr_valid,
   output logic [12:0] scr_addr,
   output logic [15:0] scr_data,
   input  logic        scr_ready,
   output logic        scr_overflow
);

   localparam int unsigned PTR_W     = $clog2(SCR_FIFO_DEPTH);
   localparam int unsigned CNT_W     = PTR_W + 1;
   localparam int unsigned RAM_WORDS = 16384;

   logic        is_ram_c;
   logic        is_scr_c;
   logic        is_kbd_c;
   logic [15:0] scr_rd_c;

   assign is_ram_c = ~addressM[14];
   assign is_scr_c = (addressM[14:13] == 2'b10);
   assign is_kbd_c = (addressM == 15'h6000);

   // Data RAM: asynchronous read, write on the edge, not cleared by reset
   logic [15:0] ram [RAM_WORDS];

   always_ff @(posedge clk) begin
      if (writeM && is_ram_c) ram[addressM[13:0]] <= outM;
   end

`ifdef HACK_SCREEN_SHADOW_EN
   localparam int unsigned SCR_WORDS = 8192;
   logic [15:0] shadow [SCR_WORDS];

   // Mirrors every screen write, including ones the FIFO drops
   always_ff @(posedge clk) begin
      if (writeM && is_scr_c) shadow[addressM[12:0]] <= outM;
   end

   assign scr_rd_c = shadow[addressM[12:0]];
`else
   assign scr_rd_c = 16'h0000;
`endif

   logic [15:0] kbd_reg;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         kbd_reg   <= '0;
         kbd_ready <= 1'b0;
      end else begin
         kbd_ready <= 1'b1;
         if (kbd_valid && kbd_ready) kbd_reg <= kbd_code;
      end
   end

   always_comb begin
      inM = '0;
      if (is_ram_c)      inM = ram[addressM[13:0]];
      else if (is_scr_c) inM = scr_rd_c;
      else if (is_kbd_c) inM = kbd_reg;
   end

   // Screen-write FIFO
   logic [12:0]      fifo_addr [SCR_FIFO_DEPTH];
   logic [15:0]      fifo_data [SCR_FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] count_next_c;
   logic             push_c;
   logic             pop_c;
   logic             full_c;
   logic             accept_c;
   logic             drop_c;

   always_comb begin
      push_c       = writeM & is_scr_c;
      pop_c        = scr_valid & scr_ready;
      full_c       = (count == CNT_W'(SCR_FIFO_DEPTH));
      // A pop in the same cycle frees the slot, so a full FIFO still accepts
      accept_c     = push_c & (~full_c | pop_c);
      drop_c       = push_c & full_c & ~pop_c;
      count_next_c = count + CNT_W'(accept_c) - CNT_W'(pop_c);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         scr_valid    <= 1'b0;
         scr_overflow <= 1'b0;
         for (int unsigned i = 0; i < SCR_FIFO_DEPTH; i++) begin
            fifo_addr[i] <= '0;
            fifo_data[i] <= '0;
         end
      end else begin
         if (accept_c) begin
            fifo_addr[wr_ptr] <= addressM[12:0];
            fifo_data[wr_ptr] <= outM;
            wr_ptr            <= wr_ptr + PTR_W'(1);
         end
         if (pop_c)  rd_ptr       <= rd_ptr + PTR_W'(1);
         if (drop_c) scr_overflow <= 1'b1;
         count     <= count_next_c;
         scr_valid <= (count_next_c != '0);
      end
   end

   assign scr_addr = fifo_addr[rd_ptr];
   assign scr_data = fifo_data[rd_ptr];

endmodule
